// File: rtl/ps2_key_tracker.sv
// ps2_key_tracker: turns the raw PS/2 scancode byte stream into registered
// held levels and one-cycle press pulses for the five game keys.
// The block tracks make, break and E0-prefixed sequences, times out a
// prefix that is never completed, and supports a synchronous clear.
module ps2_key_tracker #(
    parameter int TIMEOUT_CYCLES = 2500000
) (
    input  logic       CLOCK_50,
    input  logic       resetn,
    input  logic [7:0] received_data,
    input  logic       received_data_en,
    input  logic       clear,
    output logic       key_left,
    output logic       key_right,
    output logic       key_up,
    output logic       key_down,
    output logic       key_space,
    output logic       press_left,
    output logic       press_right,
    output logic       press_up,
    output logic       press_down,
    output logic       press_space,
    output logic       any_key,
    output logic       seq_error
);

    localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXT     = 2'd1,
        BRK     = 2'd2,
        EXT_BRK = 2'd3
    } state_t;

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n;
    // Flag bit order: 0 left, 1 right, 2 up, 3 down, 4 space.
    logic [4:0]       held, held_n, press;
    logic             any_q, err_q, err_n;
    logic [4:0]       arrow_mask, key_mask;
    logic             is_e0, is_f0;

    // Decode the incoming byte into the flag it addresses (arrows may be extended; space may not).
    always_comb begin
        arrow_mask = 5'b00000;
        case (received_data)
            8'h6B:   arrow_mask = 5'b00001;
            8'h74:   arrow_mask = 5'b00010;
            8'h75:   arrow_mask = 5'b00100;
            8'h72:   arrow_mask = 5'b01000;
            default: arrow_mask = 5'b00000;
        endcase
        key_mask = arrow_mask | {(received_data == 8'h29), 4'b0000};
        is_e0    = (received_data == 8'hE0);
        is_f0    = (received_data == 8'hF0);
    end

    // Next-state, held-flag and timeout logic; clear overrides everything, including a same-cycle byte.
    always_comb begin
        state_n = state;
        held_n  = held;
        cnt_n   = cnt;
        err_n   = 1'b0;
        if (clear) begin
            state_n = IDLE;
            held_n  = 5'b00000;
            cnt_n   = '0;
        end else if (received_data_en) begin
            cnt_n = '0;
            case (state)
                IDLE: begin
                    if (is_e0)      state_n = EXT;
                    else if (is_f0) state_n = BRK;
                    else            held_n  = held | key_mask;
                end
                EXT: begin
                    if (is_f0)      state_n = EXT_BRK;
                    else if (is_e0) state_n = EXT;
                    else begin
                        held_n  = held | arrow_mask;
                        state_n = IDLE;
                    end
                end
                BRK: begin
                    state_n = IDLE;
                    if (is_e0 || is_f0) err_n  = 1'b1;
                    else                held_n = held & ~key_mask;
                end
                EXT_BRK: begin
                    state_n = IDLE;
                    if (is_e0 || is_f0) err_n  = 1'b1;
                    else                held_n = held & ~arrow_mask;
                end
                default: state_n = IDLE;
            endcase
        end else if (state == IDLE) begin
            cnt_n = '0;
        end else if (cnt == CNT_LAST) begin
            // Prefix abandoned: drop it but keep whatever keys are held.
            state_n = IDLE;
            cnt_n   = '0;
            err_n   = 1'b1;
        end else begin
            cnt_n = cnt + 1'b1;
        end
    end

    // State, counter and registered outputs; press fires only on a 0->1 flag edge.
    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            state <= IDLE;
            cnt   <= '0;
            held  <= 5'b00000;
            press <= 5'b00000;
            any_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            held  <= held_n;
            press <= held_n & ~held;
            any_q <= |held_n;
            err_q <= err_n;
        end
    end

    assign key_left    = held[0];
    assign key_right   = held[1];
    assign key_up      = held[2];
    assign key_down    = held[3];
    assign key_space   = held[4];
    assign press_left  = press[0];
    assign press_right = press[1];
    assign press_up    = press[2];
    assign press_down  = press[3];
    assign press_space = press[4];
    assign any_key     = any_q;
    assign seq_error   = err_q;

endmodule

// File: tb/tb_ps2_key_tracker.sv
// Directed bench for ps2_key_tracker with a short prefix timeout of 16 cycles.
module tb_ps2_key_tracker;

    logic       CLOCK_50 = 1'b0;
    logic       resetn;
    logic [7:0] received_data;
    logic       received_data_en;
    logic       clear;
    logic       key_left, key_right, key_up, key_down, key_space;
    logic       press_left, press_right, press_up, press_down, press_space;
    logic       any_key, seq_error;

    int n_chk = 0;
    int n_err = 0;
    int err_pulses = 0;
    int pr_right = 0;
    int pr_space = 0;
    int pr_up = 0;
    int snap;

    ps2_key_tracker #(.TIMEOUT_CYCLES(16)) dut (
        .CLOCK_50         (CLOCK_50),
        .resetn           (resetn),
        .received_data    (received_data),
        .received_data_en (received_data_en),
        .clear            (clear),
        .key_left         (key_left),
        .key_right        (key_right),
        .key_up           (key_up),
        .key_down         (key_down),
        .key_space        (key_space),
        .press_left       (press_left),
        .press_right      (press_right),
        .press_up         (press_up),
        .press_down       (press_down),
        .press_space      (press_space),
        .any_key          (any_key),
        .seq_error        (seq_error)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    // Count pulses between edges so whole-sequence pulse totals can be checked.
    always @(negedge CLOCK_50) begin
        if (seq_error)   err_pulses <= err_pulses + 1;
        if (press_right) pr_right   <= pr_right + 1;
        if (press_space) pr_space   <= pr_space + 1;
        if (press_up)    pr_up      <= pr_up + 1;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // One clock with no strobe; returns #1 after the edge.
    task automatic tick();
        @(posedge CLOCK_50);
        #1;
    endtask

    // Present one byte for exactly one cycle; back-to-back calls give adjacent strobes.
    task automatic send(input logic [7:0] b);
        received_data    = b;
        received_data_en = 1'b1;
        @(posedge CLOCK_50);
        #1;
        received_data_en = 1'b0;
    endtask

    function automatic logic [11:0] all_out();
        return {key_left, key_right, key_up, key_down, key_space,
                press_left, press_right, press_up, press_down, press_space,
                any_key, seq_error};
    endfunction

    initial begin
        resetn           = 1'b0;
        received_data    = 8'h00;
        received_data_en = 1'b0;
        clear            = 1'b0;
        repeat (3) @(posedge CLOCK_50);
        #1;
        check("reset_outputs", 32'(all_out()), 32'h000);
        resetn = 1'b1;
        tick();

        // Extended right arrow make and break.
        snap = err_pulses;
        send(8'hE0);
        check("right_not_yet", 32'(key_right), 32'h0);
        send(8'h74);
        check("right_held", 32'(key_right), 32'h1);
        check("right_press", 32'(press_right), 32'h1);
        check("right_any", 32'(any_key), 32'h1);
        tick();
        check("right_press_one_cycle", 32'(press_right), 32'h0);
        check("right_still_held", 32'(key_right), 32'h1);
        send(8'hE0);
        send(8'hF0);
        send(8'h74);
        check("right_released", 32'(key_right), 32'h0);
        check("right_any_off", 32'(any_key), 32'h0);
        tick();
        check("right_no_error", 32'(err_pulses - snap), 32'h0);
        check("right_press_count", 32'(pr_right), 32'h1);

        // Space with typematic repeat.
        send(8'h29);
        check("space_held", 32'(key_space), 32'h1);
        check("space_press", 32'(press_space), 32'h1);
        send(8'h29);
        check("space_repeat_no_press", 32'(press_space), 32'h0);
        send(8'h29);
        send(8'hF0);
        check("space_held_before_break", 32'(key_space), 32'h1);
        send(8'h29);
        check("space_released", 32'(key_space), 32'h0);
        tick();
        check("space_press_count", 32'(pr_space), 32'h1);

        // E0 29 is not a key.
        send(8'hE0);
        send(8'h29);
        check("ext_space_ignored", 32'(key_space), 32'h0);

        // Mixed non-extended left and extended up.
        send(8'h6B);
        send(8'hE0);
        send(8'h75);
        check("mix_both_held", 32'({key_left, key_up}), 32'h3);
        send(8'hF0);
        send(8'h6B);
        check("mix_left_off_up_on", 32'({key_left, key_up, any_key}), 32'h3);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("mix_all_off", 32'({key_up, any_key}), 32'h0);

        // Prefix timeout: E0 then silence.
        snap = err_pulses;
        send(8'hE0);
        repeat (15) tick();
        check("timeout_not_yet", 32'(seq_error), 32'h0);
        tick();
        check("timeout_error", 32'(seq_error), 32'h1);
        tick();
        check("timeout_error_one_cycle", 32'(seq_error), 32'h0);
        check("timeout_pulse_count", 32'(err_pulses - snap), 32'h1);
        send(8'h29);
        check("timeout_back_in_idle", 32'(key_space), 32'h1);
        send(8'hF0);
        send(8'h29);
        send(8'h72);
        check("timeout_down_held", 32'({key_down, press_down}), 32'h3);
        send(8'hF0);
        send(8'h72);
        check("timeout_down_released", 32'(key_down), 32'h0);

        // Strobe lands exactly on the terminal count: processed, no timeout.
        snap = err_pulses;
        send(8'hE0);
        repeat (15) tick();
        send(8'h75);
        check("boundary_up_held", 32'(key_up), 32'h1);
        check("boundary_no_error", 32'(seq_error), 32'h0);
        repeat (3) tick();
        check("boundary_pulse_count", 32'(err_pulses - snap), 32'h0);
        send(8'hE0);
        send(8'hF0);
        send(8'h75);
        check("boundary_up_released", 32'(key_up), 32'h0);

        // Protocol errors leave held flags alone.
        send(8'h6B);
        snap = err_pulses;
        send(8'hF0);
        send(8'hF0);
        check("f0f0_error", 32'(seq_error), 32'h1);
        check("f0f0_left_kept", 32'(key_left), 32'h1);
        send(8'hE0);
        send(8'hF0);
        send(8'hE0);
        check("e0f0e0_error", 32'(seq_error), 32'h1);
        check("e0f0e0_left_kept", 32'(key_left), 32'h1);
        tick();
        check("proto_pulse_count", 32'(err_pulses - snap), 32'h2);
        send(8'hF0);
        send(8'h6B);
        check("proto_left_released", 32'(key_left), 32'h0);

        // Clear wins over a same-cycle strobe.
        send(8'h74);
        snap = pr_up;
        received_data    = 8'h75;
        received_data_en = 1'b1;
        clear            = 1'b1;
        tick();
        received_data_en = 1'b0;
        clear            = 1'b0;
        check("clear_all_zero", 32'(all_out()), 32'h000);
        tick();
        check("clear_no_press_up", 32'(pr_up - snap), 32'h0);

        // Reset after a lone E0 drops the prefix.
        snap = err_pulses;
        send(8'hE0);
        #3 resetn = 1'b0;
        #2;
        check("midreset_outputs", 32'(all_out()), 32'h000);
        @(negedge CLOCK_50);
        resetn = 1'b1;
        tick();
        send(8'h72);
        check("midreset_down_held", 32'(key_down), 32'h1);
        check("midreset_no_error", 32'(seq_error), 32'h0);
        repeat (20) tick();
        check("midreset_still_held", 32'(key_down), 32'h1);
        check("midreset_pulse_count", 32'(err_pulses - snap), 32'h0);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule

// File: doc/ps2_key_tracker.md
# ps2_key_tracker

Converts the raw PS/2 byte stream from `PS2_Controller` into registered key-held levels and one-cycle press pulses for the five game keys: left, right, up, down and space. It sits between `PS2_Controller` and the level FSMs (`lvl1FSM`/`lvl2FSM`/`lvl3FSM`) and the overall FSM. It replaces ad-hoc scancode handling clocked on the data strobe with a proper make/break/extended-prefix state machine in the `CLOCK_50` domain.

## Interface
Parameters:
- `TIMEOUT_CYCLES`, default 2500000: idle cycles (50 ms at 50 MHz) allowed between a prefix byte and its follow-up byte.

Ports:
- `CLOCK_50`, input, 1: system clock; all logic on its rising edge.
- `resetn`, input, 1: reset, asynchronous, active-low.
- `received_data`, input, 8: scancode byte from `PS2_Controller`.
- `received_data_en`, input, 1: one-cycle strobe; `received_data` is valid in the same cycle.
- `clear`, input, 1: synchronous drop of all held keys and return to IDLE (asserted on level change / game reset).
- `key_left`, `key_right`, `key_up`, `key_down`, `key_space`, output, 1 each: key currently held.
- `press_left`, `press_right`, `press_up`, `press_down`, `press_space`, output, 1 each: one-cycle pulse on the 0→1 transition of the matching held flag.
- `any_key`, output, 1: OR of the five held flags (registered).
- `seq_error`, output, 1: one-cycle pulse on a protocol error or prefix timeout.

## Operation
- States:
  - IDLE
  - EXT: E0 seen.
  - BRK: F0 seen.
  - EXT_BRK: E0 F0 seen.
- Key codes:
  - Left 6B, right 74, up 75, down 72: accepted both extended (E0-prefixed) and non-extended (keypad).
  - Space 29: non-extended only. E0 29 is ignored.
- Transitions, evaluated only on cycles where `received_data_en`=1:
  - IDLE:
    - E0 → EXT.
    - F0 → BRK.
    - Key code → set held flag, stay IDLE.
    - Any other byte (AA, FA, FE, E1, unknown) → ignored, stay IDLE.
  - EXT:
    - F0 → EXT_BRK.
    - E0 → stay EXT, no error.
    - Arrow code → set flag, → IDLE.
    - Other → ignored, → IDLE.
  - BRK:
    - Key code → clear flag, → IDLE.
    - E0 or F0 → `seq_error`, → IDLE.
    - Other → → IDLE.
  - EXT_BRK:
    - Arrow code → clear flag, → IDLE.
    - E0 or F0 → `seq_error`, → IDLE.
    - Other → → IDLE.
- Typematic repeat: a make code for an already-held key leaves the flag at 1 and generates no press pulse.
- Break for a key that is not held: flag stays 0, no error.
- Timeout counter:
  - Zeroed on every strobe and whenever the state is IDLE.
  - Increments each cycle in EXT, BRK or EXT_BRK.
  - On reaching `TIMEOUT_CYCLES-1` with no strobe: → IDLE, `seq_error` pulse, held flags unchanged.
- `clear`:
  - Highest priority; overrides a same-cycle strobe, and that byte is discarded.
  - Next cycle: all held flags 0, state IDLE, counter 0, no press pulses, no error.
- Counter width: `$clog2(TIMEOUT_CYCLES)` bits, saturating behaviour not needed since it is reset on reaching the terminal count.

## Timing
- Reset values (asynchronous, while `resetn`=0): state IDLE, counter 0, all outputs 0.
- Latency:
  - Strobe in cycle N → held flag and `any_key` change at the N+1 edge.
  - Press pulse is high for exactly cycle N+1.
  - `seq_error` is high for exactly cycle N+1.
- At most one byte is processed per cycle, so at most one press pulse fires per cycle.
- Consecutive strobes in adjacent cycles must each be processed (no dead cycle).
- Reset mid-sequence (e.g. after E0, before the code) discards the prefix. A following code byte is then treated as non-extended from IDLE.
- Timeout boundary:
  - A strobe arriving in the same cycle the counter hits terminal count is processed normally, with no timeout.
  - Timeout fires only if there is no strobe in that cycle.

## Test plan
- Strobes E0,74 then E0,F0,74 → `key_right` 1 from the cycle after 74, `press_right` exactly one cycle; `key_right` 0 after the final 74; `seq_error` never.
- Strobes 29, 29, 29 (typematic), then F0,29 → `key_space` 1 after the first 29, `press_space` exactly once, 0 after F0 29.
- Hold 6B and 75 (mixed non-extended/extended), then release only 6B → `key_up`=1, `key_left`=0, `any_key`=1; then release 75 → `any_key`=0.
- E0 then no byte for `TIMEOUT_CYCLES` (use 16 in sim) → `seq_error` pulse at cycle 16, state IDLE; next byte 72 sets `key_down`. Repeat with the strobe in cycle 15 → no error.
- F0,F0 → `seq_error` pulse; E0,F0,E0 → `seq_error` pulse; held flags unchanged in both cases.
- Hold 74, assert `clear` in the same cycle as a 75 strobe → next cycle all flags 0, no `press_up`. Assert `resetn`=0 after E0 alone, release, send 72 → `key_down`=1 with no error.
